// File: rtl/dccm_port_arbiter.sv
// dccm_port_arbiter: shares the single DCCM port between the LSU and a DMA/debug requester.
// The LSU always has priority. A starved DMA request forces an LSU drain and then gets a bounded burst.
// Read data (1-cycle latency) is steered back to whichever side issued the read.
//
// state | meaning
// ------+----------------------------------------------------------------
// IDLE  | normal operation; DMA is served only when the LSU leaves the port free
// DRAIN | DMA starved; hold new LSU issue until the pipeline empties
// BURST | LSU still held; DMA owns free cycles until BURST_MAX beats or valid drops
module dccm_port_arbiter #(
  parameter int XLEN         = 32,
  parameter int STARVE_LIMIT = 16,
  parameter int BURST_MAX    = 4
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            lsu_busy,
  input  logic [XLEN-1:0] lsu_dccm_raddr,
  input  logic            lsu_dccm_rvalid_in,
  input  logic [XLEN-1:0] lsu_dccm_waddr,
  input  logic            lsu_dccm_wen,
  input  logic [XLEN-1:0] lsu_dccm_wdata,
  output logic [XLEN-1:0] lsu_dccm_rdata,
  output logic            lsu_dccm_rvalid_out,
  output logic            lsu_hold,
  input  logic            dma_req_valid,
  output logic            dma_req_ready,
  input  logic            dma_req_write,
  input  logic [XLEN-1:0] dma_req_addr,
  input  logic [XLEN-1:0] dma_req_wdata,
  output logic            dma_rsp_valid,
  output logic [XLEN-1:0] dma_rsp_rdata,
  output logic [XLEN-1:0] dccm_raddr,
  output logic            dccm_rvalid_in,
  output logic [XLEN-1:0] dccm_waddr,
  output logic            dccm_wen,
  output logic [XLEN-1:0] dccm_wdata,
  input  logic [XLEN-1:0] dccm_rdata,
  input  logic            dccm_rvalid_out
);

  localparam int WCW = $clog2(STARVE_LIMIT + 1);
  localparam int BCW = $clog2(BURST_MAX + 1);
  localparam logic [WCW-1:0] WAIT_LIM  = WCW'(STARVE_LIMIT);
  localparam logic [BCW-1:0] BURST_LIM = BCW'(BURST_MAX);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    BURST = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic [WCW-1:0]  wait_cnt;
  logic [BCW-1:0]  burst_cnt, burst_cnt_nxt;
  logic            rd_owner_q;

  logic            lsu_access;
  logic            port_free;
  logic [XLEN-1:0] dma_addr_w;

  assign lsu_access    = lsu_dccm_rvalid_in | lsu_dccm_wen;
  // lsu_busy also covers the second beat of an unaligned access that is not yet on the port
  assign port_free     = ~lsu_access & ~lsu_busy;
  assign dma_req_ready = dma_req_valid & port_free;
  assign dma_addr_w    = dma_req_addr & ~XLEN'(3);

  assign lsu_hold = (state == DRAIN) | (state == BURST);

  assign dma_rsp_valid       = dccm_rvalid_out & rd_owner_q;
  assign lsu_dccm_rvalid_out = dccm_rvalid_out & ~rd_owner_q;
  assign dma_rsp_rdata       = dccm_rdata;
  assign lsu_dccm_rdata      = dccm_rdata;

  // Port mux: LSU passes straight through unless the DMA is accepted this cycle
  always_comb begin
    dccm_raddr     = lsu_dccm_raddr;
    dccm_rvalid_in = lsu_dccm_rvalid_in;
    dccm_waddr     = lsu_dccm_waddr;
    dccm_wen       = lsu_dccm_wen;
    dccm_wdata     = lsu_dccm_wdata;
    if (dma_req_ready) begin
      dccm_raddr     = dma_addr_w;
      dccm_waddr     = dma_addr_w;
      dccm_wdata     = dma_req_wdata;
      dccm_rvalid_in = ~dma_req_write;
      dccm_wen       = dma_req_write;
    end
  end

  // Remember who issued the read so next cycle's data goes back to the right side
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) rd_owner_q <= 1'b0;
    else       rd_owner_q <= dma_req_ready & ~dma_req_write;
  end

  // Starvation counter: cycles a valid DMA request has been refused, saturating
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                               wait_cnt <= '0;
    else if (!dma_req_valid || dma_req_ready) wait_cnt <= '0;
    else if (wait_cnt != WAIT_LIM)           wait_cnt <= wait_cnt + WCW'(1);
  end

  // FSM state and burst beat counter registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      burst_cnt <= '0;
    end else begin
      state     <= state_nxt;
      burst_cnt <= burst_cnt_nxt;
    end
  end

  // FSM next-state; burst_cnt is zeroed whenever IDLE is (re)entered
  always_comb begin
    state_nxt     = state;
    burst_cnt_nxt = burst_cnt;
    case (state)
      IDLE: begin
        burst_cnt_nxt = '0;
        if (wait_cnt == WAIT_LIM) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (!dma_req_valid) begin
          state_nxt     = IDLE;
          burst_cnt_nxt = '0;
        end else if (port_free) begin
          // First beat is accepted in this same cycle
          if (BURST_LIM == BCW'(1)) begin
            state_nxt     = IDLE;
            burst_cnt_nxt = '0;
          end else begin
            state_nxt     = BURST;
            burst_cnt_nxt = BCW'(1);
          end
        end
      end
      BURST: begin
        if (!dma_req_valid) begin
          state_nxt     = IDLE;
          burst_cnt_nxt = '0;
        end else if (dma_req_ready) begin
          if (burst_cnt + BCW'(1) == BURST_LIM) begin
            state_nxt     = IDLE;
            burst_cnt_nxt = '0;
          end else begin
            burst_cnt_nxt = burst_cnt + BCW'(1);
          end
        end
      end
      default: begin
        state_nxt     = IDLE;
        burst_cnt_nxt = '0;
      end
    endcase
  end

  // The LSU and DMA must never share the port in one cycle
  a_no_collision: assert property (@(posedge clk) disable iff (!rstn)
    !(dma_req_ready && lsu_access));

endmodule

// File: tb/tb_dccm_port_arbiter.sv
// tb_dccm_port_arbiter: directed checks of the DCCM port arbiter against a 1-cycle-latency memory model.
module tb_dccm_port_arbiter;

  logic        clk = 1'b0;
  logic        rstn;
  logic        lsu_busy;
  logic [31:0] lsu_dccm_raddr;
  logic        lsu_dccm_rvalid_in;
  logic [31:0] lsu_dccm_waddr;
  logic        lsu_dccm_wen;
  logic [31:0] lsu_dccm_wdata;
  logic [31:0] lsu_dccm_rdata;
  logic        lsu_dccm_rvalid_out;
  logic        lsu_hold;
  logic        dma_req_valid;
  logic        dma_req_ready;
  logic        dma_req_write;
  logic [31:0] dma_req_addr;
  logic [31:0] dma_req_wdata;
  logic        dma_rsp_valid;
  logic [31:0] dma_rsp_rdata;
  logic [31:0] dccm_raddr;
  logic        dccm_rvalid_in;
  logic [31:0] dccm_waddr;
  logic        dccm_wen;
  logic [31:0] dccm_wdata;
  logic [31:0] mem_rd = 32'h0;
  logic        mem_rv = 1'b0;
  logic [31:0] mem [0:255];

  int total = 0;
  int bad   = 0;
  int beats;

  dccm_port_arbiter #(.XLEN(32), .STARVE_LIMIT(16), .BURST_MAX(4)) dut (
    .clk(clk), .rstn(rstn), .lsu_busy(lsu_busy),
    .lsu_dccm_raddr(lsu_dccm_raddr), .lsu_dccm_rvalid_in(lsu_dccm_rvalid_in),
    .lsu_dccm_waddr(lsu_dccm_waddr), .lsu_dccm_wen(lsu_dccm_wen), .lsu_dccm_wdata(lsu_dccm_wdata),
    .lsu_dccm_rdata(lsu_dccm_rdata), .lsu_dccm_rvalid_out(lsu_dccm_rvalid_out), .lsu_hold(lsu_hold),
    .dma_req_valid(dma_req_valid), .dma_req_ready(dma_req_ready), .dma_req_write(dma_req_write),
    .dma_req_addr(dma_req_addr), .dma_req_wdata(dma_req_wdata),
    .dma_rsp_valid(dma_rsp_valid), .dma_rsp_rdata(dma_rsp_rdata),
    .dccm_raddr(dccm_raddr), .dccm_rvalid_in(dccm_rvalid_in), .dccm_waddr(dccm_waddr),
    .dccm_wen(dccm_wen), .dccm_wdata(dccm_wdata),
    .dccm_rdata(mem_rd), .dccm_rvalid_out(mem_rv)
  );

  always #5 clk = ~clk;

  // DCCM model: synchronous write, read data valid one cycle after the request
  always @(posedge clk) begin
    if (dccm_wen) mem[dccm_waddr[9:2]] <= dccm_wdata;
    if (dccm_rvalid_in) mem_rd <= mem[dccm_raddr[9:2]];
    mem_rv <= dccm_rvalid_in;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic lsu_write(input logic [31:0] a, input logic [31:0] d);
    lsu_dccm_wen = 1'b1; lsu_dccm_waddr = a; lsu_dccm_wdata = d;
    #1;
    chk("lsu_wr_pass_wen", 32'(dccm_wen), 32'd1);
    chk("lsu_wr_pass_addr", dccm_waddr, a);
    step();
    lsu_dccm_wen = 1'b0;
  endtask

  initial begin
    rstn = 1'b0; lsu_busy = 1'b0;
    lsu_dccm_raddr = '0; lsu_dccm_rvalid_in = 1'b0;
    lsu_dccm_waddr = '0; lsu_dccm_wen = 1'b0; lsu_dccm_wdata = '0;
    dma_req_valid = 1'b0; dma_req_write = 1'b0; dma_req_addr = '0; dma_req_wdata = '0;
    step(); step();
    chk("rst_hold", 32'(lsu_hold), 32'd0);
    chk("rst_ready", 32'(dma_req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(dma_rsp_valid), 32'd0);
    chk("rst_lsu_rvalid", 32'(lsu_dccm_rvalid_out), 32'd0);
    chk("rst_dccm_ctl", {30'd0, dccm_wen, dccm_rvalid_in}, 32'd0);
    rstn = 1'b1;
    step();

    lsu_write(32'h40, 32'hDEADBEEF);
    lsu_write(32'h100, 32'h11112222);
    lsu_write(32'h80, 32'hCAFEF00D);

    // LSU-only load
    lsu_busy = 1'b1; lsu_dccm_rvalid_in = 1'b1; lsu_dccm_raddr = 32'h100;
    #1;
    chk("t1_raddr", dccm_raddr, 32'h100);
    chk("t1_rvalid_in", 32'(dccm_rvalid_in), 32'd1);
    step();
    lsu_busy = 1'b0; lsu_dccm_rvalid_in = 1'b0;
    #1;
    chk("t1_lsu_rvalid", 32'(lsu_dccm_rvalid_out), 32'd1);
    chk("t1_lsu_rdata", lsu_dccm_rdata, 32'h11112222);
    chk("t1_dma_rsp", 32'(dma_rsp_valid), 32'd0);

    // DMA read on an idle port, low address bits must be ignored
    dma_req_valid = 1'b1; dma_req_write = 1'b0; dma_req_addr = 32'h43;
    #1;
    chk("t2_ready", 32'(dma_req_ready), 32'd1);
    chk("t2_raddr", dccm_raddr, 32'h40);
    chk("t2_rvalid_in", 32'(dccm_rvalid_in), 32'd1);
    step();
    dma_req_valid = 1'b0;
    #1;
    chk("t2_rsp_valid", 32'(dma_rsp_valid), 32'd1);
    chk("t2_rsp_rdata", dma_rsp_rdata, 32'hDEADBEEF);
    chk("t2_lsu_rvalid", 32'(lsu_dccm_rvalid_out), 32'd0);
    step();

    // Collision: LSU write wins, DMA write stays pending and lands next cycle
    lsu_dccm_wen = 1'b1; lsu_dccm_waddr = 32'h80; lsu_dccm_wdata = 32'h12345678;
    dma_req_valid = 1'b1; dma_req_write = 1'b1; dma_req_addr = 32'h80; dma_req_wdata = 32'hBADBAD00;
    #1;
    chk("t4_ready", 32'(dma_req_ready), 32'd0);
    chk("t4_wdata", dccm_wdata, 32'h12345678);
    step();
    lsu_dccm_wen = 1'b0;
    #1;
    chk("t4_ready_next", 32'(dma_req_ready), 32'd1);
    chk("t4_wdata_next", dccm_wdata, 32'hBADBAD00);
    step();
    dma_req_valid = 1'b0; dma_req_write = 1'b0;
    lsu_dccm_rvalid_in = 1'b1; lsu_dccm_raddr = 32'h80;
    step();
    lsu_dccm_rvalid_in = 1'b0;
    #1;
    chk("t4_readback", lsu_dccm_rdata, 32'hBADBAD00);

    // Owner split: DMA read then LSU read back-to-back
    dma_req_valid = 1'b1; dma_req_write = 1'b0; dma_req_addr = 32'h40;
    step();
    dma_req_valid = 1'b0;
    lsu_dccm_rvalid_in = 1'b1; lsu_dccm_raddr = 32'h100;
    #1;
    chk("t5_dma_valid", 32'(dma_rsp_valid), 32'd1);
    chk("t5_dma_data", dma_rsp_rdata, 32'hDEADBEEF);
    chk("t5_no_lsu_valid", 32'(lsu_dccm_rvalid_out), 32'd0);
    step();
    lsu_dccm_rvalid_in = 1'b0;
    #1;
    chk("t5_lsu_valid", 32'(lsu_dccm_rvalid_out), 32'd1);
    chk("t5_lsu_data", lsu_dccm_rdata, 32'h11112222);
    chk("t5_no_dma_valid", 32'(dma_rsp_valid), 32'd0);
    step();

    // Starvation: 16 refused cycles saturate the counter, the 17th edge enters DRAIN
    lsu_busy = 1'b1;
    dma_req_valid = 1'b1; dma_req_write = 1'b1; dma_req_addr = 32'h0; dma_req_wdata = 32'h55;
    #1;
    chk("t3_ready_busy", 32'(dma_req_ready), 32'd0);
    for (int i = 0; i < 16; i++) step();
    chk("t3_hold_16", 32'(lsu_hold), 32'd0);
    step();
    chk("t3_hold_17", 32'(lsu_hold), 32'd1);
    step();
    chk("t3_hold_drain", 32'(lsu_hold), 32'd1);
    lsu_busy = 1'b0;
    beats = 0;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (!lsu_hold) break;
      if (dma_req_ready) beats++;
      step();
    end
    chk("t3_beats", 32'(beats), 32'd4);
    chk("t3_hold_end", 32'(lsu_hold), 32'd0);
    dma_req_valid = 1'b0; dma_req_write = 1'b0;
    step();

    // Async reset inside BURST with a DMA read response in flight
    lsu_busy = 1'b1;
    dma_req_valid = 1'b1; dma_req_write = 1'b0; dma_req_addr = 32'h40;
    for (int i = 0; i < 17; i++) step();
    chk("t6_hold_drain", 32'(lsu_hold), 32'd1);
    lsu_busy = 1'b0;
    step();
    dma_req_valid = 1'b0;
    #1;
    chk("t6_hold_burst", 32'(lsu_hold), 32'd1);
    chk("t6_rsp_before", 32'(dma_rsp_valid), 32'd1);
    rstn = 1'b0;
    #1;
    chk("t6_hold_rst", 32'(lsu_hold), 32'd0);
    chk("t6_rsp_dropped", 32'(dma_rsp_valid), 32'd0);
    step();
    rstn = 1'b1;
    step();
    chk("t6_hold_after", 32'(lsu_hold), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
